// File: rtl/wt_dcache_rd_arb.sv
// -----------------------------------------------------------------------------
// wt_dcache_rd_arb
//
// Read-port arbiter for the write-through L1 dcache. Several requesters (PTW,
// load units, accelerator, wbuffer) share one tag/data read port. At most one
// read is granted per cycle. A refill/invalidate write owns the arrays outright
// and blocks all reads for that cycle.
//
// Two priority classes, selected per port by rd_prio_i:
//   - high class: round-robin among high-priority requesters
//   - low class : round-robin among low-priority requesters, with a starvation
//                 guard that forces a low-class grant after StarveLimit
//                 consecutive denied cycles
// The grant is also registered one cycle so the stage-2 hit/data mux knows
// which port owns the array readout.
//
// Parameters
//   NumPorts     number of read requesters (NumPorts-1 is the wbuffer)
//   StarveLimit  denied cycles before a forced low-class grant (1..255)
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous reset, active low
//   rd_req_i       per-port read request (level, held until ack)
//   rd_prio_i      per-port class, 1 = high priority (static after reset)
//   rd_tag_only_i  per-port "tag array only" flag
//   wr_cl_vld_i    cacheline write/invalidate occupies the arrays
//   rd_ack_o       one-hot grant, same cycle as the request
//   rd_gnt_vld_o   a grant was issued this cycle
//   rd_gnt_idx_o   index of the current grant (0 when none)
//   rd_tag_only_o  tag-only flag of the granted port (0 when none)
//   rd_vld_q_o     registered rd_gnt_vld_o (stage-2 readout valid)
//   rd_idx_q_o     registered grant index (stage-2 readout owner)
//   starve_o       forced low-class grant mode is active
// -----------------------------------------------------------------------------
module wt_dcache_rd_arb #(
  parameter int NumPorts    = 4,
  parameter int StarveLimit = 8,
  localparam int IdxW       = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] rd_req_i,
  input  logic [NumPorts-1:0] rd_prio_i,
  input  logic [NumPorts-1:0] rd_tag_only_i,
  input  logic                wr_cl_vld_i,
  output logic [NumPorts-1:0] rd_ack_o,
  output logic                rd_gnt_vld_o,
  output logic [IdxW-1:0]     rd_gnt_idx_o,
  output logic                rd_tag_only_o,
  output logic                rd_vld_q_o,
  output logic [IdxW-1:0]     rd_idx_q_o,
  output logic                starve_o
);

  typedef logic [IdxW-1:0] idx_t;

  localparam logic [7:0] StarveLim = StarveLimit[7:0];
  localparam idx_t       LastIdx   = idx_t'(NumPorts - 1);

  // First set bit of mask at or above ptr, wrapping at NumPorts.
  // Returns {found, index}.
  function automatic logic [IdxW:0] rr_pick(input logic [NumPorts-1:0] mask,
                                            input idx_t                ptr);
    logic found;
    idx_t sel;
    idx_t cand;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NumPorts; k++) begin
      cand = idx_t'((int'(ptr) + k) % NumPorts);
      if (!found && mask[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return {found, sel};
  endfunction

  function automatic idx_t rr_next(input idx_t g);
    return (g == LastIdx) ? '0 : g + idx_t'(1);
  endfunction

  logic [NumPorts-1:0] hi_req, lo_req;
  logic                any_hi, any_lo;
  logic [IdxW:0]       hi_pick, lo_pick;

  idx_t       rr_hi_q, rr_hi_d;
  idx_t       rr_lo_q, rr_lo_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;

  logic gnt_vld, gnt_lo;
  idx_t gnt_idx;

  // Class membership is purely rd_prio_i, including for the wbuffer index.
  assign hi_req  = rd_req_i &  rd_prio_i;
  assign lo_req  = rd_req_i & ~rd_prio_i;
  assign any_hi  = |hi_req;
  assign any_lo  = |lo_req;
  assign hi_pick = rr_pick(hi_req, rr_hi_q);
  assign lo_pick = rr_pick(lo_req, rr_lo_q);

  assign starve_o = (starve_cnt_q == StarveLim);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_lo  = 1'b0;
    gnt_idx = '0;
    if (!wr_cl_vld_i) begin
      if (starve_o && any_lo) begin
        gnt_vld = 1'b1;
        gnt_lo  = 1'b1;
        gnt_idx = lo_pick[IdxW-1:0];
      end else if (any_hi) begin
        gnt_vld = 1'b1;
        gnt_idx = hi_pick[IdxW-1:0];
      end else if (any_lo) begin
        gnt_vld = 1'b1;
        gnt_lo  = 1'b1;
        gnt_idx = lo_pick[IdxW-1:0];
      end
    end
  end

  always_comb begin
    rd_ack_o = '0;
    for (int i = 0; i < NumPorts; i++) begin
      rd_ack_o[i] = gnt_vld && (gnt_idx == idx_t'(i));
    end
  end

  assign rd_gnt_vld_o  = gnt_vld;
  assign rd_gnt_idx_o  = gnt_idx;
  assign rd_tag_only_o = gnt_vld & rd_tag_only_i[gnt_idx];

  // Pointers and starvation counter only move on cycles not blocked by a
  // cacheline write; a blocked cycle is invisible to the arbitration state.
  always_comb begin
    rr_hi_d      = rr_hi_q;
    rr_lo_d      = rr_lo_q;
    starve_cnt_d = starve_cnt_q;
    if (!wr_cl_vld_i) begin
      if (gnt_vld && !gnt_lo) rr_hi_d = rr_next(gnt_idx);
      if (gnt_vld &&  gnt_lo) rr_lo_d = rr_next(gnt_idx);
      if (any_lo && !(gnt_vld && gnt_lo)) begin
        if (starve_cnt_q != StarveLim) starve_cnt_d = starve_cnt_q + 8'd1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_hi_q      <= '0;
      rr_lo_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      rr_hi_q      <= rr_hi_d;
      rr_lo_q      <= rr_lo_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // ---- stage 2: readout owner ----
  // The index is only reloaded on a grant, so it keeps the last owner while
  // rd_vld_q_o is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_q_o <= 1'b0;
      rd_idx_q_o <= '0;
    end else begin
      rd_vld_q_o <= gnt_vld;
      if (gnt_vld) rd_idx_q_o <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
module tb_wt_dcache_rd_arb;

  localparam int N  = 4;
  localparam int SL = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] prio = '0;
  logic [N-1:0] tag = '0;
  logic         wr = 1'b0;
  logic [N-1:0] ack;
  logic         gnt_vld;
  logic [1:0]   gnt_idx;
  logic         tag_o;
  logic         vld_q;
  logic [1:0]   idx_q;
  logic         starve;

  wt_dcache_rd_arb #(.NumPorts(N), .StarveLimit(SL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_req_i(req), .rd_prio_i(prio),
    .rd_tag_only_i(tag), .wr_cl_vld_i(wr), .rd_ack_o(ack),
    .rd_gnt_vld_o(gnt_vld), .rd_gnt_idx_o(gnt_idx), .rd_tag_only_o(tag_o),
    .rd_vld_q_o(vld_q), .rd_idx_q_o(idx_q), .starve_o(starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ack;
    logic         vld;
    int           idx;
    logic         tag;
    logic         starve;
    logic         vq;
    int           iq;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state
  int   m_hi, m_lo, m_cnt, m_iq;
  bit   m_vq;
  int   last_g;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_cnt = 0; m_vq = 0; m_iq = 0;
  endtask

  // Drive one cycle of inputs, predict the outputs for it, advance the model.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] t, input logic w);
    logic [N-1:0] lo, hi;
    bit   starving, lo_cls;
    int   g;
    exp_t e;
    @(posedge clk);
    #1;
    req = r; tag = t; wr = w;
    lo = r & ~prio;
    hi = r & prio;
    starving = (m_cnt == SL);
    g = -1; lo_cls = 0;
    if (!w) begin
      if (starving && lo != 0)  begin g = pick(lo, m_lo); lo_cls = 1; end
      else if (hi != 0)         begin g = pick(hi, m_hi); end
      else if (lo != 0)         begin g = pick(lo, m_lo); lo_cls = 1; end
    end
    e.ack    = (g >= 0) ? N'(1) << g : '0;
    e.vld    = (g >= 0);
    e.idx    = (g >= 0) ? g : 0;
    e.tag    = (g >= 0) ? t[g] : 1'b0;
    e.starve = starving;
    e.vq     = m_vq;
    e.iq     = m_iq;
    exp_q.push_back(e);
    if (!w) begin
      if (g >= 0 && !lo_cls) m_hi = (g + 1) % N;
      if (g >= 0 &&  lo_cls) m_lo = (g + 1) % N;
      if (lo != 0 && !(g >= 0 && lo_cls)) m_cnt = (m_cnt < SL) ? m_cnt + 1 : SL;
      else m_cnt = 0;
    end
    m_vq = (g >= 0);
    if (g >= 0) m_iq = g;
    last_g = g;
  endtask

  task automatic do_reset(input logic [N-1:0] new_prio);
    @(posedge clk);
    #1;
    rst_n = 1'b0; req = '0; tag = '0; wr = 1'b0;
    prio = new_prio;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares DUT outputs against queued predictions away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_ack", int'(ack), int'(e.ack));
      chk("gnt_vld", int'(gnt_vld), int'(e.vld));
      chk("gnt_idx", int'(gnt_idx), e.idx);
      chk("tag_only", int'(tag_o), int'(e.tag));
      chk("starve", int'(starve), int'(e.starve));
      chk("vld_q", int'(vld_q), int'(e.vq));
      if (e.vq) chk("idx_q", int'(idx_q), e.iq);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pend;
    model_reset();

    // Reset state, then the round-robin pair (ports 0..2 high, 3 low).
    do_reset(4'b0111);
    step(4'b0000, 4'b0000, 1'b0);
    repeat (4) step(4'b0011, 4'b0000, 1'b0);      // acks 0,1,0,1
    step(4'b0011, 4'b0000, 1'b0);                 // pointer 2 wraps -> ack 0
    step(4'b0000, 4'b0000, 1'b0);

    // Write blocks a low request for 3 cycles, grant on the 4th.
    do_reset(4'b0111);
    repeat (3) step(4'b1000, 4'b0000, 1'b1);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Starvation: port1 high and port3 low both continuous.
    do_reset(4'b0111);
    repeat (12) step(4'b1010, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Tag-only pass-through and stage-2 valid.
    do_reset(4'b0111);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0001, 1'b0);

    // Reset mid-grant: readout valid clears without a clock edge.
    do_reset(4'b0111);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    chk("vld_q_before_rst", int'(vld_q), 1);
    rst_n = 1'b0; req = '0;
    #1;
    chk("vld_q_async_rst", int'(vld_q), 0);
    chk("ack_in_rst", int'(ack), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0011, 4'b0000, 1'b0);                 // pointer back at 0 -> ack 0

    // Wbuffer index configured high priority.
    do_reset(4'b1111);
    repeat (6) step(4'b1001, 4'b0000, 1'b0);

    // Randomized phases with requesters holding until acked.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset((ph == 0) ? 4'b0111 : (ph == 1) ? 4'b0011 :
               (ph == 2) ? 4'b0101 : 4'($urandom_range(0, 15)));
      pend = '0;
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < N; i++) begin
          if (pend[i]) pend[i] = ($urandom_range(0, 19) != 0);
          else         pend[i] = ($urandom_range(0, 9) < 4);
        end
        step(pend, 4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
        if (last_g >= 0) pend[last_g] = 1'b0;
      end
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
